// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues latency-1 imem requests and buffers {pc, instr}
// pairs in an in-order FIFO presented to decode with valid/ready; redirect flushes and restarts.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req_valid,
    output logic [31:0]                imem_req_addr,
    input  logic [31:0]                imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_q, pc_d, pend_pc_q, pend_pc_d;
    logic          pend_q, pend_d, boot_q;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          push, pop;

    // boot_q holds requests off for the cycle after reset so both reset-adjacent cycles stay quiet
    assign imem_req_valid = !reset && !boot_q && !redirect_valid
                            && (int'(count_q) + int'(pend_q) < DEPTH);
    assign imem_req_addr  = pc_q;
    assign out_valid      = !reset && !redirect_valid && (count_q != '0);
    assign out_pc         = pc_mem[rd_q];
    assign out_instr      = instr_mem[rd_q];
    assign occupancy      = reset ? '0 : count_q;
    assign push           = pend_q && !redirect_valid;
    assign pop            = out_valid && out_ready;

    always_comb begin
        pc_d      = imem_req_valid ? pc_q + 32'd4 : pc_q;
        pend_d    = imem_req_valid;
        pend_pc_d = imem_req_valid ? pc_q : pend_pc_q;
        rd_d      = rd_q + AW'(pop);
        wr_d      = wr_q + AW'(push);
        count_d   = count_q + CW'(push) - CW'(pop);
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            pend_d  = 1'b0;
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            pend_q  <= 1'b0;
            boot_q  <= 1'b1;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            boot_q    <= 1'b0;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_mem[wr_q]    <= pend_pc_q;
            instr_mem[wr_q] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus random traffic checked against a queue-based model.
module tb_fetch_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [2:0]  occupancy;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_pend_pc = '0;
    bit          m_pend = 0;
    bit          m_boot = 0;
    logic [63:0] m_q[$];
    bit          mem_pend = 0;
    logic [31:0] mem_addr = '0;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock: drive inputs, check against model, advance model at the edge
    task automatic cyc(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit exp_req, exp_ov;
        reset = rst;
        redirect_valid = rv;
        redirect_pc = rpc;
        out_ready = rdy;
        imem_rdata = mem_pend ? (mem_addr ^ 32'h13) : $urandom;
        #1;
        exp_req = !rst && !m_boot && !rv && (m_q.size() + int'(m_pend) < DEPTH);
        exp_ov  = !rst && !rv && m_q.size() != 0;
        chk("req_valid", 64'(imem_req_valid), 64'(exp_req));
        if (exp_req) chk("req_addr", 64'(imem_req_addr), 64'(m_pc));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            chk("out_pc", 64'(out_pc), 64'(m_q[0][63:32]));
            chk("out_instr", 64'(out_instr), 64'(m_q[0][31:0]));
        end
        chk("occupancy", 64'(occupancy), rst ? 64'd0 : 64'(m_q.size()));
        chk("occ_bound", 64'(occupancy <= 3'(DEPTH)), 64'd1);
        mem_pend = imem_req_valid;
        mem_addr = imem_req_addr;
        @(posedge clk);
        if (rst) begin
            m_pc = RESET_PC; m_q.delete(); m_pend = 0; m_boot = 1;
        end else begin
            m_boot = 0;
            if (rv) begin
                m_pc = {rpc[31:2], 2'b00}; m_q.delete(); m_pend = 0;
            end else begin
                if (exp_ov && rdy) void'(m_q.pop_front());
                if (m_pend) m_q.push_back({m_pend_pc, m_pend_pc ^ 32'h13});
                m_pend = exp_req;
                if (exp_req) begin
                    m_pend_pc = m_pc;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
        chk("full_occ", 64'(occupancy), 64'd4);
        chk("full_noreq", 64'(imem_req_valid), 64'd0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h100, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h203, 1);
        chk("align_req", 64'(imem_req_addr), 64'h200);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h300, 1);
        cyc(0, 1, 32'h400, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
        cyc(0, 1, 32'hFFFF_FFF8, 1);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1);
        for (int i = 0; i < 500; i++)
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                $urandom, $urandom_range(0, 2) != 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
